// File: rtl/comparador_pkg.sv
// Shared definitions for the count comparator: data width, FSM state codes
// and the saturating lap-counter increment.
// Latency: n/a (package). Backpressure: n/a.
package comparador_pkg;

  // Width of the upstream counter value and of the lap counter.
  localparam int LARGURA = 4;

  // Lap counter ceiling; the counter holds here instead of wrapping.
  localparam logic [LARGURA-1:0] VOLTAS_MAX = '1;

  // State codes double as the db_estado debug output.
  typedef enum logic [1:0] {
    OCIOSO   = 2'b00,
    CONTANDO = 2'b01,
    ATINGIDO = 2'b10,
    FIM      = 2'b11
  } estado_t;

  // Increment that sticks at VOLTAS_MAX.
  function automatic logic [LARGURA-1:0] inc_saturado(input logic [LARGURA-1:0] v);
    return (v == VOLTAS_MAX) ? v : v + LARGURA'(1);
  endfunction

endpackage

// File: rtl/detector_borda.sv
// Rising-edge detector: borda pulses for one cycle when sinal goes 0 -> 1.
// Latency: the pulse coincides with the first cycle sinal is high. Backpressure: none.
// A level held high for several cycles yields a single pulse.
// Ports: clock, reset (async, active-high), sinal (level in), borda (pulse out).
module detector_borda (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic borda
);

  // Value of sinal seen at the previous rising clock edge.
  logic anterior;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      anterior <= 1'b0;
    end else begin
      anterior <= sinal;
    end
  end

  // Used only inside the comparator, where it is consumed by flops.
  assign borda = sinal & ~anterior;

endmodule

// File: rtl/comparador_contagem.sv
// Compares an upstream 4-bit count against a loadable reference and flags a
// match once the counter has wrapped at least N_VOLTAS times since arming.
// Latency: all outputs registered, 1 cycle. Backpressure: none (free-running).
// Ports:
//   clock, reset          system clock, async active-high reset
//   contagem [3:0]        upstream count, bit 3 is the MSB
//   rco                   upstream ripple-carry (wrap) indicator
//   valor_ref [3:0]       reference value, captured when carrega_ref=1
//   carrega_ref, inicia   reference load strobe, arm / re-arm strobe
//   menor, igual, maior   one-hot contagem vs reference (registered)
//   voltas [3:0]          rco rising edges since arming, saturating at 15
//   atingido              one-cycle pulse on the qualifying match
//   pronto                high while the search is finished
//   db_estado [1:0]       current state code
module comparador_contagem
  import comparador_pkg::*;
#(
  // Number of wraps required before a match counts; meaningful range 0..15.
  parameter int N_VOLTAS = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] contagem,
  input  logic               rco,
  input  logic [LARGURA-1:0] valor_ref,
  input  logic               carrega_ref,
  input  logic               inicia,
  output logic               menor,
  output logic               igual,
  output logic               maior,
  output logic [LARGURA-1:0] voltas,
  output logic               atingido,
  output logic               pronto,
  output logic [1:0]         db_estado
);

  localparam logic [LARGURA-1:0] LIMIAR = LARGURA'(N_VOLTAS);

  estado_t            estado;
  logic [LARGURA-1:0] ref_q;
  logic               borda_rco;
  logic               casou;
  logic               voltas_ok;
  logic               qualifica;

  detector_borda u_detector_rco (
    .clock (clock),
    .reset (reset),
    .sinal (rco),
    .borda (borda_rco)
  );

  // Reference register: loads in every state. Readers below see the value
  // held before this edge, so a same-cycle load takes effect one edge later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ref_q <= '0;
    end else if (carrega_ref) begin
      ref_q <= valor_ref;
    end
  end

  // Registered one-hot magnitude comparison. Reset reports "equal" because
  // the reference register also resets to zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      menor <= 1'b0;
      igual <= 1'b1;
      maior <= 1'b0;
    end else begin
      menor <= (contagem <  ref_q);
      igual <= (contagem == ref_q);
      maior <= (contagem >  ref_q);
    end
  end

  assign casou = (contagem == ref_q);

  // voltas >= LIMIAR written as voltas + 1 > LIMIAR in one extra bit, so the
  // comparison stays meaningful when LIMIAR is zero.
  assign voltas_ok = ({1'b0, voltas} + (LARGURA + 1)'(1)) > {1'b0, LIMIAR};

  // Uses voltas before any increment happening on the same edge.
  assign qualifica = voltas_ok & casou;

  // Search FSM with registered atingido/pronto, updated together with the
  // state so they stay aligned with db_estado.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado   <= OCIOSO;
      voltas   <= '0;
      atingido <= 1'b0;
      pronto   <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (inicia) begin
            estado <= CONTANDO;
            voltas <= '0;
          end
        end

        CONTANDO: begin
          if (inicia) begin
            // Restart: clear the laps and ignore any match on this edge.
            voltas <= '0;
          end else begin
            if (qualifica) begin
              estado   <= ATINGIDO;
              atingido <= 1'b1;
            end
            if (borda_rco) begin
              voltas <= inc_saturado(voltas);
            end
          end
        end

        ATINGIDO: begin
          estado   <= FIM;
          atingido <= 1'b0;
          pronto   <= 1'b1;
        end

        FIM: begin
          // voltas stays frozen here until the next arming.
          if (inicia) begin
            estado <= CONTANDO;
            voltas <= '0;
            pronto <= 1'b0;
          end
        end

        default: begin
          estado   <= OCIOSO;
          atingido <= 1'b0;
          pronto   <= 1'b0;
        end
      endcase
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_comparador_contagem.sv
// Self-checking bench for comparador_contagem: three instances (N_VOLTAS =
// 0, 1, 15) share one stimulus stream and are compared every cycle against a
// behavioural model, plus table vectors and directed corner sequences.
module tb_comparador_contagem;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] contagem;
  logic       rco;
  logic [3:0] valor_ref;
  logic       carrega_ref;
  logic       inicia;

  logic       menor_o    [3];
  logic       igual_o    [3];
  logic       maior_o    [3];
  logic [3:0] voltas_o   [3];
  logic       atingido_o [3];
  logic       pronto_o   [3];
  logic [1:0] estado_o   [3];

  always #5 clock = ~clock;

  comparador_contagem #(.N_VOLTAS(0)) dut0 (
    .clock(clock), .reset(reset), .contagem(contagem), .rco(rco),
    .valor_ref(valor_ref), .carrega_ref(carrega_ref), .inicia(inicia),
    .menor(menor_o[0]), .igual(igual_o[0]), .maior(maior_o[0]),
    .voltas(voltas_o[0]), .atingido(atingido_o[0]), .pronto(pronto_o[0]),
    .db_estado(estado_o[0]));

  comparador_contagem #(.N_VOLTAS(1)) dut1 (
    .clock(clock), .reset(reset), .contagem(contagem), .rco(rco),
    .valor_ref(valor_ref), .carrega_ref(carrega_ref), .inicia(inicia),
    .menor(menor_o[1]), .igual(igual_o[1]), .maior(maior_o[1]),
    .voltas(voltas_o[1]), .atingido(atingido_o[1]), .pronto(pronto_o[1]),
    .db_estado(estado_o[1]));

  comparador_contagem #(.N_VOLTAS(15)) dut2 (
    .clock(clock), .reset(reset), .contagem(contagem), .rco(rco),
    .valor_ref(valor_ref), .carrega_ref(carrega_ref), .inicia(inicia),
    .menor(menor_o[2]), .igual(igual_o[2]), .maior(maior_o[2]),
    .voltas(voltas_o[2]), .atingido(atingido_o[2]), .pronto(pronto_o[2]),
    .db_estado(estado_o[2]));

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- behavioural model ----------------
  int m_ref;
  bit m_prev_rco;
  bit m_lt, m_eq, m_gt;
  bit m_busca [3];   // search armed, waiting for a qualifying match
  bit m_hit   [3];   // qualifying match seen on the last edge
  bit m_done  [3];   // search finished
  int m_laps  [3];

  function automatic int nv(input int k);
    case (k)
      0:       return 0;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  function automatic int estado_esperado(input int k);
    if (m_busca[k]) return 1;
    if (m_hit[k])   return 2;
    if (m_done[k])  return 3;
    return 0;
  endfunction

  task automatic model_reset();
    m_ref = 0; m_prev_rco = 0;
    m_lt = 0; m_eq = 1; m_gt = 0;
    for (int k = 0; k < 3; k++) begin
      m_busca[k] = 0; m_hit[k] = 0; m_done[k] = 0; m_laps[k] = 0;
    end
  endtask

  task automatic model_step();
    bit subida;
    int c;
    c = int'(contagem);
    subida = rco && !m_prev_rco;
    m_prev_rco = rco;
    m_lt = (c <  m_ref);
    m_eq = (c == m_ref);
    m_gt = (c >  m_ref);
    for (int k = 0; k < 3; k++) begin
      if (m_hit[k]) begin
        m_hit[k] = 0; m_done[k] = 1;
      end else if (m_busca[k]) begin
        if (inicia) begin
          m_laps[k] = 0;
        end else begin
          if (m_laps[k] >= nv(k) && c == m_ref) begin
            m_busca[k] = 0; m_hit[k] = 1;
          end
          if (subida && m_laps[k] < 15) m_laps[k] = m_laps[k] + 1;
        end
      end else if (inicia) begin
        m_busca[k] = 1; m_done[k] = 0; m_laps[k] = 0;
      end
    end
    if (carrega_ref) m_ref = int'(valor_ref);
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nome, input int atual, input int esperado);
    n_cmp++;
    if (atual != esperado) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, atual, esperado, $time);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("menor[%0d]", k),     int'(menor_o[k]),    int'(m_lt));
      chk($sformatf("igual[%0d]", k),     int'(igual_o[k]),    int'(m_eq));
      chk($sformatf("maior[%0d]", k),     int'(maior_o[k]),    int'(m_gt));
      chk($sformatf("voltas[%0d]", k),    int'(voltas_o[k]),   m_laps[k]);
      chk($sformatf("atingido[%0d]", k),  int'(atingido_o[k]), int'(m_hit[k]));
      chk($sformatf("pronto[%0d]", k),    int'(pronto_o[k]),   int'(m_done[k]));
      chk($sformatf("db_estado[%0d]", k), int'(estado_o[k]),   estado_esperado(k));
    end
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge.
  task automatic tick();
    @(posedge clock);
    if (reset) model_reset();
    else model_step();
    @(negedge clock);
    check_all();
  endtask

  task automatic drive(input bit cr, input int rv, input int c, input bit r, input bit ini);
    carrega_ref = cr;
    valor_ref   = 4'(rv);
    contagem    = 4'(c);
    rco         = r;
    inicia      = ini;
  endtask

  task automatic aplica_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
  endtask

  // ---------------- comparator vector table ----------------
  typedef struct {
    bit       carrega;
    int       rv;
    int       cont;
    bit       lt, eq, gt;   // expected one edge later
  } vec_t;

  vec_t tab [8];

  initial begin
    int p1, p2;

    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    model_reset();
    @(negedge clock);
    check_all();              // reset values while reset is held
    tick();
    reset = 1'b0;
    tick();

    // Loads compare against the old reference on the loading edge.
    tab[0] = '{1, 9,  9, 0, 0, 1};  // old ref 0
    tab[1] = '{0, 0,  9, 0, 1, 0};
    tab[2] = '{0, 0,  3, 1, 0, 0};
    tab[3] = '{0, 0, 12, 0, 0, 1};
    tab[4] = '{1, 3,  3, 1, 0, 0};  // old ref 9
    tab[5] = '{0, 0,  3, 0, 1, 0};
    tab[6] = '{0, 0,  0, 1, 0, 0};
    tab[7] = '{0, 0, 15, 0, 0, 1};
    for (int i = 0; i < 8; i++) begin
      drive(tab[i].carrega, tab[i].rv, tab[i].cont, 0, 0);
      tick();
      chk($sformatf("tab%0d_menor", i), int'(menor_o[1]), int'(tab[i].lt));
      chk($sformatf("tab%0d_igual", i), int'(igual_o[1]), int'(tab[i].eq));
      chk($sformatf("tab%0d_maior", i), int'(maior_o[1]), int'(tab[i].gt));
    end

    // Match only after one wrap (N_VOLTAS=1 instance).
    aplica_reset();
    drive(1, 5, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1); tick();
    p1 = 0; p2 = 0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int c = 0; c < 16; c++) begin
        drive(0, 0, c, c == 15, 0);
        tick();
        if (atingido_o[1]) begin
          if (pass == 0) p1++;
          else p2++;
        end
      end
    end
    chk("wrap_pulses_first_pass", p1, 0);
    chk("wrap_pulses_second_pass", p2, 1);
    chk("wrap_pronto", int'(pronto_o[1]), 1);
    chk("wrap_db_estado", int'(estado_o[1]), 3);

    // From FIM: re-arm and load ref=2 together; match needs one more wrap.
    drive(1, 2, 0, 0, 1); tick();
    chk("rearm_voltas", int'(voltas_o[1]), 0);
    chk("rearm_estado", int'(estado_o[1]), 1);
    drive(0, 0, 2, 0, 0); tick();
    chk("rearm_early_match", int'(atingido_o[1]), 0);
    drive(0, 0, 0, 1, 0); tick();
    drive(0, 0, 2, 0, 0); tick();
    chk("rearm_late_match", int'(atingido_o[1]), 1);
    tick();
    chk("rearm_pronto", int'(pronto_o[1]), 1);

    // rco held high for 4 cycles counts once.
    aplica_reset();
    drive(1, 15, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1); tick();
    repeat (4) begin drive(0, 0, 0, 1, 0); tick(); end
    drive(0, 0, 0, 0, 0); tick();
    chk("rco_level_voltas", int'(voltas_o[2]), 1);

    // Twenty wraps without a match saturate at 15.
    repeat (20) begin
      drive(0, 0, 0, 1, 0); tick();
      drive(0, 0, 0, 0, 0); tick();
    end
    chk("sat_voltas", int'(voltas_o[2]), 15);
    chk("sat_estado", int'(estado_o[2]), 1);

    // Async reset mid-search with voltas=3 and contagem at the reference.
    aplica_reset();
    drive(1, 7, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1); tick();
    repeat (3) begin
      drive(0, 0, 0, 1, 0); tick();
      drive(0, 0, 0, 0, 0); tick();
    end
    chk("pre_reset_voltas", int'(voltas_o[2]), 3);
    drive(0, 0, 7, 0, 0);
    #1 reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("async_menor[%0d]", k),    int'(menor_o[k]),    0);
      chk($sformatf("async_igual[%0d]", k),    int'(igual_o[k]),    1);
      chk($sformatf("async_maior[%0d]", k),    int'(maior_o[k]),    0);
      chk($sformatf("async_voltas[%0d]", k),   int'(voltas_o[k]),   0);
      chk($sformatf("async_atingido[%0d]", k), int'(atingido_o[k]), 0);
      chk($sformatf("async_pronto[%0d]", k),   int'(pronto_o[k]),   0);
      chk($sformatf("async_estado[%0d]", k),   int'(estado_o[k]),   0);
    end
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("post_reset_atingido", int'(atingido_o[1]), 0);
    tick();

    // Randomized traffic against the model.
    aplica_reset();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 7) == 0, int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), $urandom_range(0, 2) == 0,
            $urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
